// File: rtl/or_gate_core_if.sv
// or_gate_core_if: operand/result handshake bundle for or_gate_core.
// master = producer of operands and consumer of results, slave = the OR unit.
interface or_gate_core_if #(
   parameter int WIDTH = 1
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] y;
   logic             y_any;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output a, b, in_valid, out_ready,
      input  in_ready, y, y_any, out_valid
   );

   modport slave (
      input  a, b, in_valid, out_ready,
      output in_ready, y, y_any, out_valid
   );
endinterface

// File: rtl/or_gate_core.sv
// or_gate_core: registered bitwise OR unit (y = a | b, y_any = |(a | b)).
// Results are held in an output register R backed by one skid entry S, so
// in_ready can be registered and still sustain one result per cycle.
// Optional feature macro OR_GATE_COMB_EN: adds a zero-latency y_comb = a | b.
module or_gate_core #(
   parameter int WIDTH = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   or_gate_core_if.slave        bus
`ifdef OR_GATE_COMB_EN
   ,
   output logic [WIDTH-1:0]     y_comb
`endif
);

   // Packed result word: {y_any, y}
   typedef logic [WIDTH:0] result_t;

   // Build one result word from the two operands.
   function automatic result_t or_result(input logic [WIDTH-1:0] op_a,
                                         input logic [WIDTH-1:0] op_b);
      logic [WIDTH-1:0] v;
      v = op_a | op_b;
      return {|v, v};
   endfunction

   result_t r_data_r;
   logic    r_valid_r;
   result_t s_data_r;
   logic    s_full_r;
   logic    in_ready_r;

   result_t r_data_s;
   logic    r_valid_s;
   result_t s_data_s;
   logic    s_full_s;
   result_t new_result_s;
   logic    accept_s;
   logic    drain_s;

   assign accept_s = bus.in_valid & in_ready_r;
   assign drain_s  = r_valid_r & bus.out_ready;

   // Next-state for R and S: S refills R first, so ordering stays FIFO.
   always_comb begin
      new_result_s = or_result(bus.a, bus.b);
      r_data_s     = r_data_r;
      r_valid_s    = r_valid_r;
      s_data_s     = s_data_r;
      s_full_s     = s_full_r;
      if (!r_valid_r || drain_s) begin
         if (s_full_r) begin
            r_data_s  = s_data_r;
            r_valid_s = 1'b1;
            if (accept_s) begin
               s_data_s = new_result_s;
               s_full_s = 1'b1;
            end else begin
               s_full_s = 1'b0;
            end
         end else begin
            if (accept_s) begin
               r_data_s  = new_result_s;
               r_valid_s = 1'b1;
            end else begin
               r_valid_s = 1'b0;
            end
         end
      end else begin
         // R is stalled; an accept can only happen while S is empty.
         if (accept_s) begin
            s_data_s = new_result_s;
            s_full_s = 1'b1;
         end else begin
            s_full_s = s_full_r;
         end
      end
   end

   // State registers; in_ready is precomputed as "S will be empty".
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data_r   <= '0;
         r_valid_r  <= 1'b0;
         s_data_r   <= '0;
         s_full_r   <= 1'b0;
         in_ready_r <= 1'b1;
      end else begin
         r_data_r   <= r_data_s;
         r_valid_r  <= r_valid_s;
         s_data_r   <= s_data_s;
         s_full_r   <= s_full_s;
         in_ready_r <= ~s_full_s;
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = r_valid_r;
   assign bus.y         = r_data_r[WIDTH-1:0];
   assign bus.y_any     = r_data_r[WIDTH];

`ifdef OR_GATE_COMB_EN
   // Bypass path: pure combinational OR, ignores handshake and reset.
   assign y_comb = bus.a | bus.b;
`endif

endmodule

// File: tb/tb_or_gate_core.sv
// tb_or_gate_core: randomized + directed bench for or_gate_core.
// An 8-bit instance is checked against a queue model of results in flight;
// a 1-bit instance shares the handshake and sees bit 0 of the operands.
module tb_or_gate_core;

   logic clk;
   logic rst_n;
   int   err_cnt;
   int   chk_cnt;

   or_gate_core_if #(.WIDTH(8)) bus8 ();
   or_gate_core_if #(.WIDTH(1)) bus1 ();

   assign bus1.a         = bus8.a[0];
   assign bus1.b         = bus8.b[0];
   assign bus1.in_valid  = bus8.in_valid;
   assign bus1.out_ready = bus8.out_ready;

`ifdef OR_GATE_COMB_EN
   logic [7:0] y_comb8;
   logic [0:0] y_comb1;
`endif

   or_gate_core #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8)
`ifdef OR_GATE_COMB_EN
      ,
      .y_comb(y_comb8)
`endif
   );

   or_gate_core #(.WIDTH(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
`ifdef OR_GATE_COMB_EN
      ,
      .y_comb(y_comb1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: results accepted but not yet consumed, oldest first: {any, y}
   logic [8:0] exp_q[$];

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: check outputs at the falling edge, update model, advance.
   task automatic tick();
      logic acc;
      logic drn;
      logic [8:0] e;
      @(negedge clk);
      check_val("in_ready",   bus8.in_ready,  64'(exp_q.size() < 2));
      check_val("out_valid",  bus8.out_valid, 64'(exp_q.size() > 0));
      check_val("in_ready1",  bus1.in_ready,  64'(exp_q.size() < 2));
      check_val("out_valid1", bus1.out_valid, 64'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
         e = exp_q[0];
         check_val("y",      bus8.y,     64'(e[7:0]));
         check_val("y_any",  bus8.y_any, 64'(e[8]));
         check_val("y_w1",   bus1.y,     64'(e[0]));
         check_val("any_w1", bus1.y_any, 64'(e[0]));
      end
      acc = bus8.in_valid && (exp_q.size() < 2);
      drn = bus8.out_ready && (exp_q.size() > 0);
      if (drn) void'(exp_q.pop_front());
      if (acc) begin
         e[7:0] = bus8.a | bus8.b;
         e[8]   = (e[7:0] != 8'h00);
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] da, input logic [7:0] db);
      bus8.in_valid = v;
      bus8.a        = da;
      bus8.b        = db;
   endtask

   logic [7:0] tt_a[4];
   logic [7:0] tt_b[4];

   initial begin
      err_cnt = 0;
      chk_cnt = 0;
      rst_n   = 1'b0;
      drive(1'b0, 8'h00, 8'h00);
      bus8.out_ready = 1'b1;
      #1;
      check_val("rst_out_valid", bus8.out_valid, 64'd0);
      check_val("rst_y",         bus8.y,         64'd0);
      check_val("rst_y_any",     bus8.y_any,     64'd0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_val("rst_in_ready", bus8.in_ready, 64'd1);

      // Truth table on bit 0 (WIDTH=1 instance): 00, 01, 10, 11
      tt_a[0] = 8'h00; tt_b[0] = 8'h00;
      tt_a[1] = 8'h00; tt_b[1] = 8'h01;
      tt_a[2] = 8'h01; tt_b[2] = 8'h00;
      tt_a[3] = 8'h01; tt_b[3] = 8'h01;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, tt_a[i], tt_b[i]);
         tick();
         check_val("tt_y1",   bus1.y,     64'(i != 0));
         check_val("tt_any1", bus1.y_any, 64'(i != 0));
      end

      // Directed 8-bit values
      drive(1'b1, 8'hA0, 8'h05);
      tick();
      check_val("a5_y",   bus8.y,     64'h0A5);
      check_val("a5_any", bus8.y_any, 64'd1);
      drive(1'b1, 8'h00, 8'h00);
      tick();
      check_val("zero_y",   bus8.y,     64'h000);
      check_val("zero_any", bus8.y_any, 64'd0);
      drive(1'b0, 8'h00, 8'h00);
      tick();

      // Backpressure: three beats offered, only two fit
      bus8.out_ready = 1'b0;
      drive(1'b1, 8'h01, 8'h00); tick();
      drive(1'b1, 8'h02, 8'h00); tick();
      drive(1'b1, 8'h04, 8'h00); tick();
      check_val("bp_in_ready_low", bus8.in_ready, 64'd0);
      check_val("bp_head",         bus8.y,        64'h001);
      tick();
      bus8.out_ready = 1'b1;
      tick();
      check_val("bp_second", bus8.y, 64'h002);
      tick();
      check_val("bp_third", bus8.y, 64'h004);
      drive(1'b0, 8'h00, 8'h00);
      tick();
      tick();

      // Streaming with out_ready toggling, random beats (a/b random even when idle)
      for (int i = 0; i < 60; i++) begin
         bus8.out_ready = (i % 2 == 0);
         drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom));
         tick();
      end
      // Fully random handshake
      for (int i = 0; i < 200; i++) begin
         bus8.out_ready = 1'($urandom);
         drive(1'($urandom), 8'($urandom), 8'($urandom));
         tick();
      end

      // Reset mid-stream while a result is held
      bus8.out_ready = 1'b0;
      drive(1'b1, 8'h3C, 8'h00); tick();
      drive(1'b1, 8'h55, 8'h00); tick();
      check_val("pre_rst_valid", bus8.out_valid, 64'd1);
      drive(1'b0, 8'h00, 8'h00);
      #2 rst_n = 1'b0;
      #1;
      check_val("mid_rst_valid", bus8.out_valid, 64'd0);
      check_val("mid_rst_y",     bus8.y,         64'd0);
      check_val("mid_rst_any",   bus8.y_any,     64'd0);
      exp_q.delete();
      bus8.out_ready = 1'b1;
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      drive(1'b1, 8'h81, 8'h00);
      tick();
      check_val("post_rst_y",     bus8.y,         64'h081);
      check_val("post_rst_valid", bus8.out_valid, 64'd1);
      drive(1'b0, 8'h00, 8'h00);
      tick();
      tick();

`ifdef OR_GATE_COMB_EN
      // Combinational bypass works in reset with no valid
      rst_n = 1'b0;
      drive(1'b0, 8'h0F, 8'hF0);
      #1;
      check_val("y_comb", y_comb8, 64'h0FF);
      drive(1'b0, 8'h00, 8'h00);
      #1;
      check_val("y_comb_zero", y_comb8, 64'h000);
      rst_n = 1'b1;
`endif

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
